boot_rom_obi_adapter: RTL and testbench
=======================================

Name: boot_rom_obi_adapter

Overview:
- OBI-style slave adapter directly upstream of the debug/boot ROM. It accepts instruction/data fetches from the core or debug module, decodes the ROM window, drives the ROM's simple req/addr port and captures the one-cycle-late rdata.
- It returns in-order responses with error signalling.
- A response FIFO with rready back-pressure decouples the ROM's fixed latency from a stalling requester.

Parameters:
- BaseAddr, 32'h1A00_0000, byte base address of the ROM window.
- RomWords, 2, ROM size in 32-bit words; window is [BaseAddr, BaseAddr+4*RomWords).
- RespDepth, 3, max outstanding transactions (in-flight stage plus FIFO entries), >=2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- obi_req_i  in  1  request valid
- obi_gnt_o  out  1  request accepted this cycle
- obi_addr_i  in  32  byte address
- obi_we_i  in  1  write enable
- obi_be_i  in  4  byte enables (ignored for reads)
- obi_wdata_i  in  32  write data (never stored)
- obi_rvalid_o  out  1  response valid
- obi_rready_i  in  1  requester accepts response
- obi_rdata_o  out  32  response data
- obi_err_o  out  1  response error
- rom_req_o  out  1  ROM read strobe
- rom_addr_o  out  32  ROM-relative byte address
- rom_rdata_i  in  32  ROM data, valid the cycle after rom_req_o

Behaviour:
- Reset values:
  - obi_gnt_o=0 while rst_ni low; obi_rvalid_o=0, obi_rdata_o=0, obi_err_o=0, rom_req_o=0, rom_addr_o=0.
  - Occupancy=0, FIFO empty.
- Occupancy and grant:
  - occ = in-flight stage valid + FIFO count.
  - obi_gnt_o = (occ < RespDepth), computed from registered state only; no combinational path from obi_rready_i or obi_req_i.
  - Accept = obi_req_i & obi_gnt_o.
- Decode: hit = obi_addr_i >= BaseAddr && obi_addr_i < BaseAddr+4*RomWords, unsigned 32-bit compare. obi_addr_i[1:0] ignored.
- Cycle N, accepted hit read: rom_req_o=1 and rom_addr_o = obi_addr_i - BaseAddr (mod 2^32). In-flight stage loads {valid=1, err=0, use_rom=1}.
- Cycle N, accepted miss or write: rom_req_o=0. In-flight stage loads {valid=1, err=1, use_rom=0}. Write behaviour is modified by the optional feature.
- rom_req_o is 0 on any cycle without an accepted hit read. rom_addr_o holds its last value.
- Cycle N+1: in-flight entry pushes into the FIFO with data = use_rom ? rom_rdata_i : 32'h0.
- FIFO output:
  - obi_rvalid_o = FIFO not empty; obi_rdata_o and obi_err_o come from the head.
  - Earliest rvalid is N+2 (registered).
  - Pop when obi_rvalid_o & obi_rready_i.
  - Head data must stay stable while rvalid=1 and rready=0.
- Simultaneous events:
  - Push and pop in the same cycle are both honoured and the count is unchanged.
  - Accept plus push plus pop in the same cycle is legal.
- Responses are strictly in acceptance order, including interleaved hit, miss and error.
- Full throughput (one accept per cycle) with rready tied high requires RespDepth>=3. With RespDepth=2 throughput is 2 per 3 cycles.
- FIFO pointers wrap modulo RespDepth. The count never exceeds RespDepth, guaranteed by the grant rule.
- Reset mid-operation: all pending and in-flight responses are discarded with no rvalid after release. The first grant is in the cycle after rst_ni rises.
- obi_wdata_i and obi_be_i never reach the ROM.

Optional Feature:
- Macro BOOT_ROM_ADAPTER_WR_ERR_EN.
- Defined: any accepted write (hit or miss) responds err=1, rdata=0.
- Undefined: hit writes are absorbed silently and respond err=0, rdata=0; miss writes still respond err=1.
- No ROM access for writes in either case.

Test Plan:
- Reset release, read BaseAddr+0 with rom_rdata_i=32'h1C000_0B7 -> gnt in the first cycle after reset; rom_req_o=1, rom_addr_o=0; rvalid two cycles later with rdata=32'h1C0000B7, err=0.
- Back-to-back reads at +0, +4, +8, +0 with rready=1 -> gnt every cycle; rvalid on 4 consecutive cycles. The +8 read returns err=1, rdata=0, with no rom_req on its cycle. Order is preserved.
- rready=0 while issuing 5 reads -> exactly 3 grants, then gnt=0; head data stable. Raise rready -> 3 responses drain in order, then gnt returns.
- Write to BaseAddr+4 -> err=1 with BOOT_ROM_ADAPTER_WR_ERR_EN defined, err=0 without it; rom_req_o stays 0 in both cases.
- Address BaseAddr-4 and 32'hFFFF_FFFC -> err=1, rdata=0, no rom_req.
- Assert rst_ni low with 2 responses pending and rready=0 -> rvalid=0 and gnt=0 during reset; no stale rvalid after release.

Source files
------------

// File: rtl/boot_rom_obi_adapter.sv
// boot_rom_obi_adapter: OBI slave front-end for the boot/debug ROM with an in-order response FIFO.
// Optional macro BOOT_ROM_ADAPTER_WR_ERR_EN: when defined, every accepted write responds err=1;
// otherwise writes that hit the ROM window are absorbed silently (err=0).
module boot_rom_obi_adapter #(
  parameter logic [31:0] BaseAddr  = 32'h1A00_0000,
  parameter int unsigned RomWords  = 2,
  parameter int unsigned RespDepth = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        obi_req_i,
  output logic        obi_gnt_o,
  input  logic [31:0] obi_addr_i,
  input  logic        obi_we_i,
  input  logic [3:0]  obi_be_i,
  input  logic [31:0] obi_wdata_i,
  output logic        obi_rvalid_o,
  input  logic        obi_rready_i,
  output logic [31:0] obi_rdata_o,
  output logic        obi_err_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_rdata_i
);
  localparam int unsigned PW = $clog2(RespDepth);
  localparam int unsigned CW = $clog2(RespDepth + 1);
  localparam logic [32:0] EndAddr = {1'b0, BaseAddr} + 33'(4 * RomWords);
`ifdef BOOT_ROM_ADAPTER_WR_ERR_EN
  localparam logic WrErr = 1'b1;
`else
  localparam logic WrErr = 1'b0;
`endif
  logic          r_rdy, r_ifl_vld, r_ifl_err, r_ifl_rom;
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rom_addr;
  logic [31:0]   r_data [RespDepth];
  logic          r_err  [RespDepth];
  logic [31:0]   w_addr;
  logic [CW-1:0] w_occ;
  logic          w_hit, w_acc, w_rd_hit, w_push, w_pop, w_rvalid, w_unused;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(RespDepth - 1)) ? '0 : p + 1'b1;
  endfunction

  // Write payload is intentionally dropped; the ROM is read-only.
  assign w_unused     = ^{obi_wdata_i, obi_be_i};
  assign w_addr       = {obi_addr_i[31:2], 2'b00};
  assign w_hit        = (w_addr >= BaseAddr) && ({1'b0, w_addr} < EndAddr);
  assign w_occ        = r_cnt + CW'(r_ifl_vld);
  // Grant depends on registered state only; r_rdy delays the first grant past reset release.
  assign obi_gnt_o    = r_rdy && (w_occ < CW'(RespDepth));
  assign w_acc        = obi_req_i && obi_gnt_o;
  assign w_rd_hit     = w_acc && w_hit && !obi_we_i;
  assign rom_req_o    = w_rd_hit;
  assign rom_addr_o   = w_rd_hit ? obi_addr_i - BaseAddr : r_rom_addr;
  assign w_push       = r_ifl_vld;
  assign w_rvalid     = r_cnt != '0;
  assign w_pop        = w_rvalid && obi_rready_i;
  assign obi_rvalid_o = w_rvalid;
  assign obi_rdata_o  = w_rvalid ? r_data[r_rptr] : '0;
  assign obi_err_o    = w_rvalid && r_err[r_rptr];

  // Control state: in-flight stage, FIFO pointers/count and held ROM address.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rdy      <= 1'b0;
      r_ifl_vld  <= 1'b0;
      r_ifl_err  <= 1'b0;
      r_ifl_rom  <= 1'b0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_cnt      <= '0;
      r_rom_addr <= '0;
    end else begin
      r_rdy     <= 1'b1;
      r_ifl_vld <= w_acc;
      r_ifl_err <= !w_hit || (obi_we_i && WrErr);
      r_ifl_rom <= w_rd_hit;
      if (w_rd_hit) r_rom_addr <= rom_addr_o;
      if (w_push) r_wptr <= nxt(r_wptr);
      if (w_pop) r_rptr <= nxt(r_rptr);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Response storage; contents are only observed while the count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data[r_wptr] <= r_ifl_rom ? rom_rdata_i : '0;
      r_err[r_wptr]  <= r_ifl_err;
    end
  end
endmodule

// File: tb/tb_boot_rom_obi_adapter.sv
// tb_boot_rom_obi_adapter: table-driven check of the boot ROM OBI adapter with a 2-word ROM model.
module tb_boot_rom_obi_adapter;
  localparam logic [31:0] B  = 32'h1A00_0000;
  localparam logic [31:0] W0 = 32'h1C00_00B7;
  localparam logic [31:0] W1 = 32'hDEAD_BEEF;
`ifdef BOOT_ROM_ADAPTER_WR_ERR_EN
  localparam logic EXP_WR_ERR = 1'b1;
`else
  localparam logic EXP_WR_ERR = 1'b0;
`endif

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic        rr;
    logic        gnt;
    logic        rreq;
    logic [31:0] raddr;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  logic        clk, rst_n, req, gnt, we, rvalid, rready, err, rom_req;
  logic [31:0] addr, wdata, rdata, rom_addr, rom_rdata;
  logic [3:0]  be;
  int          checks, errors;
  vec_t        tbl[$];

  boot_rom_obi_adapter dut (
    .clk_i(clk), .rst_ni(rst_n), .obi_req_i(req), .obi_gnt_o(gnt), .obi_addr_i(addr),
    .obi_we_i(we), .obi_be_i(be), .obi_wdata_i(wdata), .obi_rvalid_o(rvalid),
    .obi_rready_i(rready), .obi_rdata_o(rdata), .obi_err_o(err), .rom_req_o(rom_req),
    .rom_addr_o(rom_addr), .rom_rdata_i(rom_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (rom_req) rom_rdata <= rom_addr[2] ? W1 : W0;

  function automatic vec_t mk(input logic rq, input logic [31:0] a, input logic w, input logic r,
                              input logic g, input logic rrq, input logic [31:0] ra,
                              input logic rv, input logic [31:0] rd, input logic e);
    vec_t v;
    v.req = rq; v.addr = a; v.we = w; v.rr = r; v.gnt = g; v.rreq = rrq;
    v.raddr = ra; v.rvalid = rv; v.rdata = rd; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk); #1;
    req = v.req; addr = v.addr; we = v.we; rready = v.rr;
    @(negedge clk);
    chk($sformatf("v%0d gnt", idx), 32'(gnt), 32'(v.gnt));
    chk($sformatf("v%0d rom_req", idx), 32'(rom_req), 32'(v.rreq));
    chk($sformatf("v%0d rom_addr", idx), rom_addr, v.raddr);
    chk($sformatf("v%0d rvalid", idx), 32'(rvalid), 32'(v.rvalid));
    if (v.rvalid) begin
      chk($sformatf("v%0d rdata", idx), rdata, v.rdata);
      chk($sformatf("v%0d err", idx), 32'(err), 32'(v.err));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    checks = 0; errors = 0;
    rst_n = 1'b0; req = 1'b1; addr = B; we = 1'b0; rready = 1'b0;
    wdata = 32'hA5A5_A5A5; be = 4'hF; rom_rdata = '0;
    // back-to-back reads with an out-of-window word in the middle
    tbl.push_back(mk(1, B,     0, 1, 1, 1, 0, 0, 0,  0));
    tbl.push_back(mk(1, B + 4, 0, 1, 1, 1, 4, 0, 0,  0));
    tbl.push_back(mk(1, B + 8, 0, 1, 1, 0, 4, 1, W0, 0));
    tbl.push_back(mk(1, B,     0, 1, 1, 1, 0, 1, W1, 0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 1, 0,  1));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 1, W0, 0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 0, 0,  0));
    // back-pressure: only three of five requests granted, head stays stable
    tbl.push_back(mk(1, B,     0, 0, 1, 1, 0, 0, 0,  0));
    tbl.push_back(mk(1, B + 4, 0, 0, 1, 1, 4, 0, 0,  0));
    tbl.push_back(mk(1, B,     0, 0, 1, 1, 0, 1, W0, 0));
    tbl.push_back(mk(1, B + 4, 0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(1, B + 4, 0, 0, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(0, B + 4, 0, 1, 0, 0, 0, 1, W0, 0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 1, W1, 0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 1, W0, 0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 0, 0,  0));
    // write inside the window: never reaches the ROM
    tbl.push_back(mk(1, B + 4, 1, 1, 1, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 0, 0,  0));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 1, 0,  EXP_WR_ERR));
    tbl.push_back(mk(0, B,     0, 1, 1, 0, 0, 0, 0,  0));
    // just below the window and top of the address space
    tbl.push_back(mk(1, B - 4,        0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32'hFFFF_FFFC, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, B,            0, 1, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, B,            0, 1, 1, 0, 0, 1, 0, 1));
    tbl.push_back(mk(0, B,            0, 1, 1, 0, 0, 0, 0, 0));

    @(negedge clk);
    chk("reset gnt", 32'(gnt), 0);
    chk("reset rvalid", 32'(rvalid), 0);
    chk("reset rom_req", 32'(rom_req), 0);
    chk("reset rom_addr", rom_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    foreach (tbl[i]) apply(tbl[i], i);

    // reset with two responses pending and rready low
    apply(mk(1, B,     0, 0, 1, 1, 0, 0, 0,  0), 100);
    apply(mk(1, B + 4, 0, 0, 1, 1, 4, 0, 0,  0), 101);
    apply(mk(0, B,     0, 0, 1, 0, 4, 1, W0, 0), 102);
    apply(mk(0, B,     0, 0, 1, 0, 4, 1, W0, 0), 103);
    @(posedge clk); #1;
    rst_n = 1'b0; req = 1'b1; addr = B;
    #1;
    chk("mid-reset rvalid", 32'(rvalid), 0);
    chk("mid-reset gnt", 32'(gnt), 0);
    chk("mid-reset rom_req", 32'(rom_req), 0);
    repeat (2) begin
      @(negedge clk);
      chk("in-reset rvalid", 32'(rvalid), 0);
      chk("in-reset gnt", 32'(gnt), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; req = 1'b0;
    @(negedge clk);
    chk("release-cycle gnt", 32'(gnt), 0);
    repeat (3) begin
      @(negedge clk);
      chk("post-reset rvalid", 32'(rvalid), 0);
    end
    @(posedge clk); #1;
    req = 1'b1; addr = B + 4; rready = 1'b1;
    @(negedge clk);
    chk("post-reset gnt", 32'(gnt), 1);
    @(posedge clk); #1;
    req = 1'b0;
    n = 0;
    @(negedge clk);
    while (!rvalid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("post-reset resp rvalid", 32'(rvalid), 1);
    chk("post-reset resp rdata", rdata, W1);
    chk("post-reset resp err", 32'(err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
